// File: rtl/stream_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stream_ctrl_pkg
// Shared definitions for the stream controller:
//   - state_e : controller state encoding (2-bit)
//   - ch_w()  : channel index width for a given channel count
// -----------------------------------------------------------------------------
package stream_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // At least one bit, so a single-channel build still has a legal index port.
  function automatic int ch_w(input int n_ch);
    return (n_ch <= 1) ? 1 : $clog2(n_ch);
  endfunction

endpackage : stream_ctrl_pkg

// File: rtl/stream_ctrl_rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// Registered rising-edge detector for a vector of level inputs.
//   clk, rst  : clock, asynchronous active-high reset
//   din_i[W]  : level inputs, synchronous to clk
//   rise_o[W] : din_i & ~previous din_i (a level held high across reset
//               release produces a rise on the first edge)
// -----------------------------------------------------------------------------
module rise_detect #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] prev_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= '0;
    else     prev_q <= din_i;
  end

  assign rise_o = din_i & ~prev_q;

endmodule : rise_detect

// File: rtl/stream_ctrl.sv
// -----------------------------------------------------------------------------
// stream_ctrl
// Arbitrates N_CH producer channels, enables one at a time and forwards its
// words into the FIFO write port. Handles back-pressure, stop-then-drain,
// saturating accepted-word count, sticky drop flag and optional parity.
//
// Optional feature macro: STREAM_CTRL_PARITY_EN (even parity of last wr_data;
// when undefined, parity is tied 0).
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start[N_CH]            per-channel start request levels
//   stop                   stop request level
//   src_valid[N_CH]        per-channel word valid
//   src_data[N_CH*DATA_W]  channel i at [i*DATA_W +: DATA_W]
//   src_en[N_CH]           one-hot producer enable (RUN only)
//   wr_en, wr_data         FIFO write strobe / data (registered)
//   fifo_full, fifo_empty  FIFO status flags
//   rd_valid               read side still presenting a word
//   active_ch[CH_W]        latched channel index
//   busy                   controller not idle
//   word_cnt[CNT_W]        accepted writes since last start, saturating
//   drop                   sticky: word offered while not writable
//   parity                 even parity of last written word
// -----------------------------------------------------------------------------
module stream_ctrl
  import stream_ctrl_pkg::*;
#(
  parameter  int N_CH   = 2,
  parameter  int DATA_W = 16,
  parameter  int CNT_W  = 16,
  localparam int CH_W   = ch_w(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        start,
  input  logic                   stop,
  input  logic [N_CH-1:0]        src_valid,
  input  logic [N_CH*DATA_W-1:0] src_data,
  output logic [N_CH-1:0]        src_en,
  output logic                   wr_en,
  output logic [DATA_W-1:0]      wr_data,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  input  logic                   rd_valid,
  output logic [CH_W-1:0]        active_ch,
  output logic                   busy,
  output logic [CNT_W-1:0]       word_cnt,
  output logic                   drop,
  output logic                   parity
);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     active_ch_q, active_ch_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic                drop_q, drop_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic [N_CH-1:0]     start_rise;
  logic                stop_rise;
  logic [CH_W-1:0]     first_ch;
  logic                sel_valid;
  logic [DATA_W-1:0]   sel_data;
  logic                write_fire;

  rise_detect #(.W(N_CH)) u_start_rise (
    .clk    (clk),
    .rst    (rst),
    .din_i  (start),
    .rise_o (start_rise)
  );

  rise_detect #(.W(1)) u_stop_rise (
    .clk    (clk),
    .rst    (rst),
    .din_i  (stop),
    .rise_o (stop_rise)
  );

  // Lowest-index rise wins: scan downward so the last hit is the lowest.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    first_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (start_rise[i]) first_ch = CH_W'(i);
    end
  end

  // Mux the latched channel's valid/data; also decode the one-hot enable.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    src_en    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (active_ch_q == CH_W'(i)) begin
        sel_valid = src_valid[i];
        sel_data  = src_data[i*DATA_W +: DATA_W];
        src_en[i] = (state_q == S_RUN);
      end
    end
  end

  assign write_fire = sel_valid && (state_q == S_RUN) && !fifo_full;

  always_comb begin
    state_d     = state_q;
    active_ch_d = active_ch_q;
    word_cnt_d  = word_cnt_q;
    drop_d      = drop_q;
    wr_en_d     = write_fire;
    wr_data_d   = write_fire ? sel_data : wr_data_q;

    if (write_fire && (word_cnt_q != '1)) word_cnt_d = word_cnt_q + CNT_W'(1);

    if (sel_valid && ((state_q == S_WAIT) || (state_q == S_DRAIN) ||
                      ((state_q == S_RUN) && fifo_full)))
      drop_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (|start_rise) begin
          state_d     = S_RUN;
          active_ch_d = first_ch;
          word_cnt_d  = '0;
          drop_d      = 1'b0;
        end
      end
      S_RUN: begin
        // Stop outranks back-pressure.
        if (stop_rise)      state_d = S_DRAIN;
        else if (fifo_full) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (stop_rise)       state_d = S_DRAIN;
        else if (!fifo_full) state_d = S_RUN;
      end
      S_DRAIN: begin
        if (fifo_empty && !rd_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      active_ch_q <= '0;
      word_cnt_q  <= '0;
      drop_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      active_ch_q <= active_ch_d;
      word_cnt_q  <= word_cnt_d;
      drop_q      <= drop_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
    end
  end

`ifdef STREAM_CTRL_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             parity_q <= 1'b0;
    else if (write_fire) parity_q <= ^sel_data;
  end

  assign parity = parity_q;
`else
  assign parity = 1'b0;
`endif

  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;
  assign active_ch = active_ch_q;
  assign busy      = (state_q != S_IDLE);
  assign word_cnt  = word_cnt_q;
  assign drop      = drop_q;

endmodule : stream_ctrl

// File: doc/stream_ctrl.md
# stream_ctrl

Parametrised source-to-FIFO stream controller: arbitrates N_CH producer channels (counter/sequence generators), enables exactly one at a time, and forwards its words into the write side of the clock-crossing FIFO. Handles FIFO back-pressure, a stop-then-drain sequence, accepted-word counting, drop detection and optional even-parity generation. Sits between the producer blocks and the FIFO wrapper in the top-level datapath.

## Interface
- N_CH, 2, number of producer channels (≥1)
- DATA_W, 16, producer/FIFO word width
- CNT_W, 16, width of accepted-word counter
- CH_W (derived), max(1, clog2(N_CH)), channel index width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  N_CH  per-channel start request levels, synchronous to clk
- stop  in  1  stop request level, synchronous to clk
- src_valid  in  N_CH  per-channel word-valid strobe
- src_data  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- src_en  out  N_CH  one-hot producer enable
- wr_en  out  1  FIFO write strobe
- wr_data  out  DATA_W  FIFO write data
- fifo_full  in  1  FIFO full flag
- fifo_empty  in  1  FIFO empty flag
- rd_valid  in  1  read side still presenting a word
- active_ch  out  CH_W  latched channel index
- busy  out  1  state ≠ IDLE
- word_cnt  out  CNT_W  accepted writes since last start, saturating
- drop  out  1  sticky: a word was offered while not writable
- parity  out  1  even parity of last wr_data

## Operation
- Rise detection: prev register per start bit and stop, reset 0; rise = din & ~prev. Input high at reset release yields a rise on the first edge.
- States: IDLE, RUN, WAIT, DRAIN.
- IDLE: any start rise → RUN; lowest set index wins on simultaneous rises; active_ch latched; word_cnt and drop cleared. Stop rise ignored.
- RUN: stop rise → DRAIN (priority over full); else fifo_full → WAIT. Start rises ignored.
- WAIT: stop rise → DRAIN; else ~fifo_full → RUN.
- DRAIN: fifo_empty & ~rd_valid → IDLE; otherwise hold. Stop/start ignored.
- src_en = one-hot(active_ch) when state = RUN, else all 0 (decoded from state register).
- Write: src_valid[active_ch] & state = RUN & ~fifo_full → wr_en = 1 next cycle, wr_data = that channel's word; one write per valid. Valids on non-active channels are ignored.
- drop set when src_valid[active_ch] while state ∈ {WAIT, DRAIN} or (RUN & fifo_full); cleared only on IDLE→RUN.
- word_cnt increments on each wr_en; saturates at 2^CNT_W−1.
- Reset values: state IDLE, src_en 0, wr_en 0, wr_data 0, active_ch 0, busy 0, word_cnt 0, drop 0, parity 0.
- Reset mid-operation returns immediately to IDLE with reset values; FIFO contents are not the block's concern.

## Timing
- Start high first sampled at edge k → state RUN and src_en valid after edge k.
- src_valid sampled at edge m (writable) → wr_en/wr_data/parity valid for the cycle after m; latency 1.
- fifo_full sampled at edge m in RUN → no write from edge m; WAIT after edge m; src_en low the cycle after m.
- Stop rise at edge k → DRAIN after k; IDLE one cycle after first edge sampling fifo_empty=1 and rd_valid=0.
- word_cnt updates on the edge where wr_en is registered high (same edge as wr_data).

## Configuration
- STREAM_CTRL_PARITY_EN defined: parity register loads XOR-reduction of the written word alongside wr_data; holds between writes.
- Not defined: parity tied 0, no reduction logic.

## Structure
- Package stream_ctrl_pkg: state encoding (S_IDLE=0, S_RUN=1, S_WAIT=2, S_DRAIN=3, 2-bit) and CH_W helper function.
- Sub-module rise_detect (parameter W): prev register + rise logic; one instance for start (W=N_CH), one for stop (W=1).

## Test plan
- N_CH=2: start[1] rise, src_valid[1] with 16'h00A5 → src_en=2'b10, next cycle wr_en=1, wr_data=16'h00A5, parity=0, word_cnt=1.
- start=2'b11 same cycle → active_ch=0, src_en=2'b01.
- RUN, fifo_full=1 during src_valid with 16'h0001 → no wr_en, drop=1, state WAIT, src_en=0; fifo_full=0 → RUN, src_en restored.
- Stop rise while fifo_empty=0 → DRAIN, busy=1; set fifo_empty=1, rd_valid=1 → stays; rd_valid=0 → IDLE, busy=0.
- CNT_W=4, 20 writes → word_cnt stops at 15; new start clears to 0.
- rst asserted in RUN mid-write → all outputs at reset values same cycle; with macro undefined parity stays 0 for 16'h0007.
